fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register; it produces the instruction stream that the decode stage consumes.
- Holds the PC and drives a combinational-read instruction memory.
- Pre-decodes the opcode so the word after a two-word (immediate) instruction is tagged as an immediate. Decode then treats that word as a NOP.
- Handles boot-vector load, pipeline stall and branch redirect.

---
 rtl/fetch_stage.sv | 56 +++++
 tb/tb_fetch_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch and IF/ID register with immediate-word pre-decode
module fetch_stage #(
  parameter int          PC_W    = 16,
  parameter logic [15:0] IMM_OPS = 16'h00C0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic            valid_out,
  output logic            imm_flag_out
);
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_IMM  = 2'd2;
  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_arm;
  assign imem_addr = r_pc;
  assign w_pc_inc  = r_pc + 1'b1;
  // an immediate word never arms IMM itself
  assign w_arm     = (r_state != S_IMM) && IMM_OPS[imem_rdata[15:12]];
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_BOOT;
      r_pc         <= '0;
      instr_out    <= '0;
      pc_out       <= '0;
      valid_out    <= 1'b0;
      imm_flag_out <= 1'b0;
    end else if (r_state == S_BOOT) begin
      r_pc    <= PC_W'(imem_rdata);
      r_state <= S_RUN;
    end else if (redirect_en) begin
      r_pc         <= redirect_pc;
      r_state      <= S_RUN;
      instr_out    <= '0;
      pc_out       <= '0;
      valid_out    <= 1'b0;
      imm_flag_out <= 1'b0;
    end else if (!stall) begin
      r_pc         <= w_pc_inc;
      r_state      <= w_arm ? S_IMM : S_RUN;
      instr_out    <= imem_rdata;
      pc_out       <= w_pc_inc;
      valid_out    <= 1'b1;
      imm_flag_out <= r_state == S_IMM;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a behavioural model
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic        imm_flag_out;
  logic [15:0] mem [0:65535];
  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcout;
    logic        v;
    logic        f;
    logic [15:0] addr;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] m_pc, m_instr, m_pcout;
  logic        m_v, m_f, m_boot, m_imm;
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
    .imm_flag_out(imm_flag_out)
  );
  assign imem_rdata = mem[imem_addr];
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("instr_out", instr_out, e.instr);
      check("pc_out", pc_out, e.pcout);
      check("valid_out", {15'd0, valid_out}, {15'd0, e.v});
      check("imm_flag_out", {15'd0, imm_flag_out}, {15'd0, e.f});
      check("imem_addr", imem_addr, e.addr);
    end
  end
  // Behavioural reference: a fetch is "take the word at pc, step pc"; opcodes 6/7 own the next word.
  task automatic step(input logic rst, input logic st, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    #1;
    reset = rst; stall = st; redirect_en = rd; redirect_pc = rpc;
    if (!rst) begin
      m_pc = 0; m_instr = 0; m_pcout = 0; m_v = 0; m_f = 0; m_boot = 1; m_imm = 0;
    end else if (m_boot) begin
      m_pc = mem[m_pc];
      m_boot = 0;
    end else if (rd) begin
      m_pc = rpc; m_instr = 0; m_pcout = 0; m_v = 0; m_f = 0; m_imm = 0;
    end else if (!st) begin
      m_instr = mem[m_pc];
      m_pcout = m_pc + 16'd1;
      m_v = 1;
      m_f = m_imm;
      m_imm = !m_imm && (mem[m_pc][15:12] inside {4'h6, 4'h7});
      m_pc = m_pc + 16'd1;
    end
    q.push_back('{instr: m_instr, pcout: m_pcout, v: m_v, f: m_f, addr: m_pc});
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'h0010;
    mem[16'h0010] = 16'h6200;
    mem[16'h0011] = 16'h7FFF;
    mem[16'h0012] = 16'h1000;
    mem[16'h0040] = 16'h6000;
    mem[16'hFFFF] = 16'h1234;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 40 && m_pc != 16'h0020; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 16'h0010);
    step(1, 0, 0, 0);
    step(1, 1, 1, 16'h0040);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 16'hFFFF);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 16'h0010);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic r, s, d;
      logic [15:0] t;
      r = $urandom_range(99) >= 2;
      s = $urandom_range(99) < 25;
      d = $urandom_range(99) < 10;
      t = ($urandom_range(3) == 0) ? 16'($urandom_range(65535, 65530)) : 16'($urandom);
      step(r, s, d, t);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
